// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the decoder select scanner: state encoding and
// the select-to-one-hot helper.
package decoder_scan_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_DWELL = 1'b1;

  // Widest select the helper supports; callers truncate to their own N.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_N     = 1 << MAX_SEL_W;

  typedef enum logic {
    IDLE  = ST_IDLE,
    DWELL = ST_DWELL
  } state_t;

  function automatic logic [MAX_N-1:0] onehot_of(input logic [MAX_SEL_W-1:0] sel);
    return MAX_N'(1) << sel;
  endfunction

endpackage

// File: rtl/decoder_select_scanner_rr_next_index.sv
// Combinational round-robin search: first unmasked channel starting at base
// (or base+1, with base as the final candidate).
module rr_next_index #(
  parameter int SEL_W = 1
) (
  input  logic [SEL_W-1:0]      base,
  input  logic [(1<<SEL_W)-1:0] skip_mask,
  input  logic                  include_base_first,
  output logic [SEL_W-1:0]      next_idx,
  output logic                  none_found
);

  localparam int N = 1 << SEL_W;

  logic [SEL_W-1:0] first;
  logic [SEL_W-1:0] cand;

  assign first = include_base_first ? base : base + SEL_W'(1);

  // Walk candidates from farthest to nearest so the nearest unmasked one wins.
  always_comb begin
    next_idx   = '0;
    none_found = 1'b1;
    cand       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = first + SEL_W'(i);
      if (!skip_mask[cand]) begin
        next_idx   = cand;
        none_found = 1'b0;
      end
    end
  end

endmodule

// File: rtl/decoder_select_scanner.sv
// Round-robin select sequencer for a 1-to-N decoder: holds each unmasked
// channel for dwell+1 cycles and reports wrap and all-masked events.
module decoder_select_scanner
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W   = 1,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [(1<<SEL_W)-1:0] skip_mask,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_valid,
  output logic [(1<<SEL_W)-1:0] onehot,
  output logic                  busy,
  output logic                  wrap,
  output logic                  err
);

  localparam int N = 1 << SEL_W;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   base;
  logic [SEL_W-1:0]   next_idx;
  logic               none_found;
  logic               from_idle;
  logic [N-1:0]       next_onehot;

  // One searcher serves both the start search (from 0, inclusive) and the
  // advance search (from sel+1, sel last).
  assign from_idle   = (state == IDLE);
  assign base        = from_idle ? '0 : sel;
  assign next_onehot = N'(onehot_of(MAX_SEL_W'(next_idx)));

  rr_next_index #(
    .SEL_W(SEL_W)
  ) u_next (
    .base              (base),
    .skip_mask         (skip_mask),
    .include_base_first(from_idle),
    .next_idx          (next_idx),
    .none_found        (none_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      onehot    <= '0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        sel_valid <= 1'b0;
        onehot    <= '0;
        busy      <= 1'b0;
        cnt       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (none_found) begin
                err <= 1'b1;
              end else begin
                sel       <= next_idx;
                onehot    <= next_onehot;
                sel_valid <= 1'b1;
                busy      <= 1'b1;
                cnt       <= dwell;
                state     <= DWELL;
              end
            end
          end
          DWELL: begin
            if (cnt != '0) begin
              cnt <= cnt - DWELL_W'(1);
            end else if (none_found) begin
              // Everything masked: abandon the scan but leave sel where it was.
              state     <= IDLE;
              sel_valid <= 1'b0;
              onehot    <= '0;
              busy      <= 1'b0;
              cnt       <= '0;
              err       <= 1'b1;
            end else begin
              sel    <= next_idx;
              onehot <= next_onehot;
              cnt    <= dwell;
              wrap   <= (next_idx <= sel);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_select_scanner.sv
// Bench for decoder_select_scanner: directed SEL_W=1 sequence checks plus a
// SEL_W=2 instance tracked every cycle by a behavioural model.
module tb_decoder_select_scanner;

  logic clk;
  logic rst_n;

  // SEL_W=1 instance
  logic       start1, stop1;
  logic [3:0] dwell1;
  logic [1:0] mask1;
  logic       sel1;
  logic       valid1, busy1, wrap1, err1;
  logic [1:0] onehot1;

  // SEL_W=2 instance
  logic       start2, stop2;
  logic [3:0] dwell2;
  logic [3:0] mask2;
  logic [1:0] sel2;
  logic       valid2, busy2, wrap2, err2;
  logic [3:0] onehot2;

  int checks = 0;
  int fails  = 0;

  // Model state for the SEL_W=2 instance
  bit m_active;
  int m_sel;
  int m_cnt;
  bit m_wrap;
  bit m_err;

  decoder_select_scanner #(.SEL_W(1), .DWELL_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .dwell(dwell1),
    .skip_mask(mask1), .sel(sel1), .sel_valid(valid1), .onehot(onehot1),
    .busy(busy1), .wrap(wrap1), .err(err1)
  );

  decoder_select_scanner #(.SEL_W(2), .DWELL_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .dwell(dwell2),
    .skip_mask(mask2), .sel(sel2), .sel_valid(valid2), .onehot(onehot2),
    .busy(busy2), .wrap(wrap2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_sel = 0; m_cnt = 0; m_wrap = 0; m_err = 0;
  endtask

  // One clock of the scanner rules for N=4, using inputs present at the edge.
  task automatic model_step();
    int c;
    bit found;
    m_wrap = 0;
    m_err  = 0;
    if (stop2) begin
      m_active = 0;
      m_cnt    = 0;
    end else if (!m_active) begin
      if (start2) begin
        found = 0;
        for (int i = 0; i < 4 && !found; i++)
          if (!mask2[i]) begin found = 1; m_sel = i; end
        if (found) begin m_active = 1; m_cnt = dwell2; end
        else m_err = 1;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else begin
      found = 0;
      c = 0;
      for (int j = 1; j <= 4 && !found; j++) begin
        c = (m_sel + j) % 4;
        if (!mask2[c]) found = 1;
      end
      if (!found) begin
        m_active = 0; m_err = 1; m_cnt = 0;
      end else begin
        m_wrap = (c <= m_sel);
        m_sel  = c;
        m_cnt  = dwell2;
      end
    end
  endtask

  task automatic compare2();
    check("sel2",    32'(sel2),    32'(m_sel));
    check("valid2",  32'(valid2),  32'(m_active));
    check("busy2",   32'(busy2),   32'(m_active));
    check("onehot2", 32'(onehot2), m_active ? (32'd1 << m_sel) : 32'd0);
    check("wrap2",   32'(wrap2),   32'(m_wrap));
    check("err2",    32'(err2),    32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare2();
  endtask

  int exp_sel1 [6] = '{0, 0, 0, 1, 1, 1};

  initial begin
    rst_n  = 1'b0;
    start1 = 0; stop1 = 0; dwell1 = 4'd2; mask1 = 2'b00;
    start2 = 0; stop2 = 0; dwell2 = 4'd0; mask2 = 4'b0101;
    model_reset();
    #3;
    check("reset_valid1",  32'(valid1),  0);
    check("reset_onehot1", 32'(onehot1), 0);
    compare2();
    #9 rst_n = 1'b1;

    // SEL_W=1: dwell=2, nothing masked -> 0,0,0,1,1,1 then stop on the wrapping advance
    start1 = 1;
    tick();
    start1 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      check("seq_sel1",    32'(sel1),    32'(exp_sel1[i]));
      check("seq_onehot1", 32'(onehot1), exp_sel1[i] == 1 ? 32'd2 : 32'd1);
      check("seq_valid1",  32'(valid1),  1);
      check("seq_wrap1",   32'(wrap1),   0);
      check("seq_busy1",   32'(busy1),   1);
    end
    stop1 = 1;
    tick();
    stop1 = 0;
    check("stop_valid1",  32'(valid1),  0);
    check("stop_onehot1", 32'(onehot1), 0);
    check("stop_wrap1",   32'(wrap1),   0);
    check("stop_busy1",   32'(busy1),   0);

    // Uninterrupted SEL_W=1 scan: wrap on the 1->0 advance
    start1 = 1;
    tick();
    start1 = 0;
    repeat (5) tick();
    tick();
    check("wrap_sel1",    32'(sel1),    0);
    check("wrap_pulse1",  32'(wrap1),   1);
    check("wrap_onehot1", 32'(onehot1), 1);
    tick();
    check("wrap_clear1",  32'(wrap1),   0);

    // Async reset mid-scan clears outputs before the next edge
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_valid1",  32'(valid1),  0);
    check("async_onehot1", 32'(onehot1), 0);
    check("async_busy1",   32'(busy1),   0);
    check("async_sel1",    32'(sel1),    0);
    compare2();
    #1 rst_n = 1'b1;
    tick();
    check("post_reset_valid1", 32'(valid1), 0);

    // start and stop together stay idle
    start1 = 1; stop1 = 1;
    tick();
    start1 = 0; stop1 = 0;
    check("startstop_valid1", 32'(valid1), 0);
    check("startstop_busy1",  32'(busy1),  0);

    // SEL_W=2: mask 0101, dwell 0 -> 1,3,1,3 with wrap on 3->1
    mask2 = 4'b0101; dwell2 = 4'd0; start2 = 1;
    tick();
    start2 = 0;
    check("m0101_first", 32'(sel2), 1);
    repeat (6) tick();

    // All channels masked mid-dwell -> err at the next advance
    mask2 = 4'b1111;
    repeat (3) tick();

    // Start with everything masked -> err, stays idle
    start2 = 1;
    tick();
    start2 = 0;
    tick();

    // Longest dwell, single unmasked channel re-selects itself
    mask2 = 4'b1011; dwell2 = 4'd15; start2 = 1;
    tick();
    start2 = 0;
    repeat (40) tick();
    stop2 = 1;
    tick();
    stop2 = 0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      start2 = ($urandom_range(0, 3) == 0);
      stop2  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) mask2 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) dwell2 = 4'd15;
      else dwell2 = 4'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
